// File: rtl/boot_loader_if.sv
// Host byte channel plus RAM write port of the boot loader.
// Host drives master; the loader takes slave.
interface boot_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;

  modport master (output rx_valid, rx_data,
                  input  rx_ready, mem_addr, mem_wdata, mem_we);
  modport slave  (input  rx_valid, rx_data,
                  output rx_ready, mem_addr, mem_wdata, mem_we);
endinterface

// File: rtl/boot_loader.sv
// Length-prefixed, checksummed byte-stream image loader. It writes the image word by word
// into RAM and holds the CPU in reset until the checksum verifies.
module boot_loader #(
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic          clk,
  input  logic          n_reset,
  boot_loader_if.slave  bus,
  output logic          cpu_n_reset,
  output logic          done,
  output logic          error,
  output logic [31:0]   words_loaded
);

  typedef enum logic [2:0] {LEN, DATA, CSUM, DONE, ERROR} state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [23:0] sh;
  logic [31:0] len;
  logic [7:0]  csum;
  logic        xfer;
  logic [31:0] word_full;

  assign xfer      = bus.rx_valid & bus.rx_ready;
  // Bytes arrive LSB first: the newest byte lands on top.
  assign word_full = {bus.rx_data, sh};

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state         <= LEN;
      byte_idx      <= 2'd0;
      sh            <= 24'd0;
      len           <= 32'd0;
      csum          <= 8'd0;
      words_loaded  <= 32'd0;
      bus.rx_ready  <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      bus.mem_we    <= 1'b0;
      cpu_n_reset   <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      bus.mem_we   <= 1'b0;
      bus.rx_ready <= (state == LEN) || (state == DATA) || (state == CSUM);
      case (state)
        LEN: if (xfer) begin
          byte_idx <= byte_idx + 2'd1;
          sh       <= word_full[31:8];
          if (byte_idx == 2'd3) begin
            len <= word_full;
            if (word_full > 32'(MAX_WORDS)) begin
              state        <= ERROR;
              error        <= 1'b1;
              bus.rx_ready <= 1'b0;
            end else if (word_full == 32'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: if (xfer) begin
          byte_idx <= byte_idx + 2'd1;
          sh       <= word_full[31:8];
          csum     <= csum + bus.rx_data;
          if (byte_idx == 2'd3) begin
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= word_full;
            bus.mem_addr  <= BASE_ADDR + (words_loaded << 2);
            words_loaded  <= words_loaded + 32'd1;
            if (words_loaded + 32'd1 == len) state <= CSUM;
          end
        end
        CSUM: if (xfer) begin
          bus.rx_ready <= 1'b0;
          if (bus.rx_data == csum) begin
            state       <= DONE;
            done        <= 1'b1;
            cpu_n_reset <= 1'b1;
          end else begin
            state <= ERROR;
            error <= 1'b1;
          end
        end
        default: bus.rx_ready <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Randomized self-checking bench for boot_loader, checked against a byte-level stream model.
module tb_boot_loader;
  localparam int          MAXW = 256;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        n_reset = 1'b1;
  logic        cpu_n_reset, done, error;
  logic [31:0] words_loaded;

  boot_loader_if bus();

  boot_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .n_reset(n_reset), .bus(bus), .cpu_n_reset(cpu_n_reset),
    .done(done), .error(error), .words_loaded(words_loaded));

  always #5 clk = ~clk;

  int          tests = 0, fails = 0;
  logic [31:0] ram [0:MAXW-1];
  int          wr_cnt = 0;
  bit          mon_en = 0;
  bit          exp_we = 0;
  logic [31:0] exp_data, exp_addr;
  logic [31:0] img [$];
  int          idx;

  // Write-port monitor: every cycle mem_we must match what the stream dictates.
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      if (bus.mem_we !== exp_we) begin
        fails++; $display("FAIL mem_we_timing @%0t: got %b expected %b", $time, bus.mem_we, exp_we);
      end
      if (bus.mem_we === 1'b1 && exp_we) begin
        tests++;
        if (bus.mem_addr !== exp_addr || bus.mem_wdata !== exp_data) begin
          fails++; $display("FAIL mem_write: got %h@%h expected %h@%h", bus.mem_wdata, bus.mem_addr, exp_data, exp_addr);
        end
      end
    end
    if (bus.mem_we === 1'b1) begin
      wr_cnt++;
      idx = int'((bus.mem_addr - BASE) >> 2);
      if (idx >= 0 && idx < MAXW) ram[idx] = bus.mem_wdata;
    end
    exp_we = 0;
  end

  function automatic logic [7:0] img_sum(int n);
    int s = 0;
    for (int w = 0; w < n; w++)
      s += img[w][7:0] + img[w][15:8] + img[w][23:16] + img[w][31:24];
    return 8'(s % 256);
  endfunction

  function automatic int ram_errs(int n);
    int e = 0;
    for (int w = 0; w < n; w++) if (ram[w] !== img[w]) e++;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    n_reset = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    wr_cnt = 0;
    for (int i = 0; i < MAXW; i++) ram[i] = 32'hDEAD_BEEF;
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int t = 0;
    repeat ($urandom_range(0, max_gap)) begin
      @(negedge clk); bus.rx_valid = 1'b0; bus.rx_data = 8'($urandom);
    end
    @(negedge clk);
    bus.rx_valid = 1'b1; bus.rx_data = b;
    while (bus.rx_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    tests++;
    if (t >= 50) begin
      fails++; $display("FAIL rx_ready_timeout: rx_ready %b expected 1", bus.rx_ready);
    end else @(posedge clk);
  endtask

  // Sends length, all words of img (unless oversize) and the checksum byte cs.
  task automatic run_stream(input logic [31:0] n, input logic [7:0] cs, input int gap);
    for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], gap);
    if (n <= 32'(MAXW)) begin
      for (int w = 0; w < int'(n); w++)
        for (int k = 0; k < 4; k++) begin
          send_byte(img[w][8*k +: 8], gap);
          if (k == 3) begin exp_we = 1; exp_data = img[w]; exp_addr = BASE + 32'(w) * 4; end
        end
      #1;
      tests++;
      if (cpu_n_reset !== 1'b0 || done !== 1'b0) begin
        fails++; $display("FAIL pre_csum_state: cpu_n_reset %b done %b expected 0 0", cpu_n_reset, done);
      end
      send_byte(cs, gap);
    end
    #1;
    tests++;
    if ((n <= 32'(MAXW) && cs == img_sum(int'(n))) ? {done, cpu_n_reset, error} !== 3'b110
                                                   : {done, cpu_n_reset, error} !== 3'b001) begin
      fails++; $display("FAIL end_of_stream_flags: done/cpu_n_reset/error %b%b%b for len %0d", done, cpu_n_reset, error, n);
    end
    @(negedge clk); bus.rx_valid = 1'b0;
  endtask

  task automatic fill_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  task automatic test_reset();
    #2 n_reset = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    #1;
    tests++;
    if ({cpu_n_reset, done, error, bus.rx_ready, bus.mem_we} !== 5'b0 || words_loaded !== 32'd0) begin
      fails++; $display("FAIL reset_outputs: flags %b%b%b%b%b wl %0d expected 0", cpu_n_reset, done, error, bus.rx_ready, bus.mem_we, words_loaded);
    end
    @(negedge clk); n_reset = 1'b1; #1;
    tests++;
    if (bus.rx_ready !== 1'b0) begin fails++; $display("FAIL rx_ready_release: got %b expected 0", bus.rx_ready); end
    @(posedge clk); #1;
    tests++;
    if (bus.rx_ready !== 1'b1) begin fails++; $display("FAIL rx_ready_first_clk: got %b expected 1", bus.rx_ready); end
    mon_en = 1;
  endtask

  task automatic test_basic();
    do_reset();
    img = '{32'h00000093, 32'h00100113};
    run_stream(32'd2, 8'hB7, 0);
    repeat (2) @(negedge clk);
    tests++;
    if ({done, error, cpu_n_reset, bus.rx_ready} !== 4'b1010 || words_loaded !== 32'd2 || wr_cnt != 2 || ram_errs(2) != 0) begin
      fails++; $display("FAIL basic_load: flags %b%b%b%b wl %0d writes %0d ram_errs %0d expected 1010 2 2 0", done, error, cpu_n_reset, bus.rx_ready, words_loaded, wr_cnt, ram_errs(2));
    end
  endtask

  task automatic test_bad_csum();
    do_reset();
    img = '{32'h00000093, 32'h00100113};
    run_stream(32'd2, 8'hB6, 0);
    repeat (2) @(negedge clk);
    tests++;
    if ({done, error, cpu_n_reset, bus.rx_ready} !== 4'b0100 || wr_cnt != 2 || ram_errs(2) != 0) begin
      fails++; $display("FAIL bad_csum: flags %b%b%b%b writes %0d expected 0100 2", done, error, cpu_n_reset, bus.rx_ready, wr_cnt);
    end
  endtask

  task automatic test_oversize();
    do_reset();
    img.delete();
    run_stream(32'(MAXW + 1), 8'h00, 0);
    tests++;
    if (error !== 1'b1 || bus.rx_ready !== 1'b0 || wr_cnt != 0 || words_loaded !== 32'd0) begin
      fails++; $display("FAIL oversize: error %b rx_ready %b writes %0d expected 1 0 0", error, bus.rx_ready, wr_cnt);
    end
    do_reset();
    run_stream(32'h8000_0000, 8'h00, 2);
  endtask

  task automatic test_empty();
    do_reset();
    img.delete();
    run_stream(32'd0, 8'h00, 0);
    tests++;
    if (done !== 1'b1 || wr_cnt != 0) begin fails++; $display("FAIL empty_good: done %b writes %0d expected 1 0", done, wr_cnt); end
    do_reset();
    run_stream(32'd0, 8'h01, 0);
    tests++;
    if (error !== 1'b1 || done !== 1'b0 || wr_cnt != 0) begin fails++; $display("FAIL empty_bad: error %b done %b expected 1 0", error, done); end
  endtask

  task automatic test_throttled();
    do_reset();
    fill_img(14);
    run_stream(32'd14, img_sum(14), 4);
    tests++;
    if (ram_errs(14) != 0 || words_loaded !== 32'd14 || wr_cnt != 14) begin
      fails++; $display("FAIL throttled: ram_errs %0d wl %0d writes %0d expected 0 14 14", ram_errs(14), words_loaded, wr_cnt);
    end
  endtask

  task automatic test_max_len();
    do_reset();
    fill_img(MAXW);
    run_stream(32'(MAXW), img_sum(MAXW), 0);
    tests++;
    if (ram_errs(MAXW) != 0 || words_loaded !== 32'(MAXW) || done !== 1'b1) begin
      fails++; $display("FAIL max_len: ram_errs %0d wl %0d done %b expected 0 %0d 1", ram_errs(MAXW), words_loaded, done, MAXW);
    end
  endtask

  task automatic test_sticky();
    int w0;
    w0 = wr_cnt;
    @(negedge clk); bus.rx_valid = 1'b1; bus.rx_data = 8'h5A;
    repeat (6) @(negedge clk);
    bus.rx_valid = 1'b0;
    tests++;
    if ({done, error, cpu_n_reset, bus.rx_ready} !== 4'b1010 || wr_cnt != w0 || words_loaded !== 32'(MAXW)) begin
      fails++; $display("FAIL sticky_done: flags %b%b%b%b writes %0d expected 1010 %0d", done, error, cpu_n_reset, bus.rx_ready, wr_cnt, w0);
    end
    #2 n_reset = 1'b0; #1;
    tests++;
    if (cpu_n_reset !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL async_reset_done: cpu_n_reset %b done %b expected 0 0", cpu_n_reset, done); end
    @(negedge clk); n_reset = 1'b1;
  endtask

  task automatic test_reset_midload();
    do_reset();
    fill_img(5);
    for (int k = 0; k < 4; k++) send_byte(8'(5 >> (8 * k)), 0);
    send_byte(img[0][7:0], 0);
    send_byte(img[0][15:8], 0);
    #2 n_reset = 1'b0; bus.rx_valid = 1'b0; #1;
    tests++;
    if ({cpu_n_reset, bus.rx_ready, done, error} !== 4'b0 || words_loaded !== 32'd0) begin
      fails++; $display("FAIL midload_reset: flags %b%b%b%b wl %0d expected 0", cpu_n_reset, bus.rx_ready, done, error, words_loaded);
    end
    @(negedge clk); n_reset = 1'b1;
    run_stream(32'd5, img_sum(5), 1);
    tests++;
    if (words_loaded !== 32'd5 || ram_errs(5) != 0 || wr_cnt != 5) begin
      fails++; $display("FAIL midload_reload: wl %0d ram_errs %0d writes %0d expected 5 0 5", words_loaded, ram_errs(5), wr_cnt);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n; logic [7:0] cs; bit good;
      n = $urandom_range(1, 12);
      good = 1'($urandom_range(0, 1));
      do_reset();
      fill_img(n);
      cs = good ? img_sum(n) : img_sum(n) ^ (8'h1 << $urandom_range(0, 7));
      run_stream(32'(n), cs, 3);
      repeat (2) @(negedge clk);
      tests++;
      if ({done, error, cpu_n_reset} !== (good ? 3'b101 : 3'b010) || words_loaded !== 32'(n) || ram_errs(n) != 0) begin
        fails++; $display("FAIL random_%0d: flags %b%b%b wl %0d ram_errs %0d expected good=%0b wl %0d", it, done, error, cpu_n_reset, words_loaded, ram_errs(n), good, n);
      end
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    test_reset();
    test_basic();
    test_bad_csum();
    test_oversize();
    test_empty();
    test_throttled();
    test_max_len();
    test_sticky();
    test_reset_midload();
    test_random();
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
